// File: rtl/pipeline_pkg.sv
// Shared pipeline typedefs: stage payload structs and the skid-register
// occupancy state used by every pipe_skid_reg instance.
package pipeline_pkg;

    localparam int XLEN = 32;

    // Fetch-to-decode payload carried between front-end stages.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_payload_t;

    // Execute-to-writeback payload.
    typedef struct packed {
        logic [4:0]      rd;
        logic            wen;
        logic [XLEN-1:0] result;
    } wb_payload_t;

    // Occupancy of a two-entry skid register: nothing held, head only,
    // head plus skid entry.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    // Number of entries held for a given occupancy state.
    function automatic logic [1:0] skid_count(input skid_state_t s);
        logic [1:0] n;
        case (s)
            EMPTY:   n = 2'd0;
            ONE:     n = 2'd1;
            FULL:    n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline skid register. The head entry drives out_data directly
// from a flop; the skid entry absorbs the one word that can arrive while the
// head is blocked, so in_ready never depends combinationally on out_ready.
module pipe_skid_reg
    import pipeline_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter bit CLEAR_ON_FLUSH = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             stall,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       count
);

    skid_state_t      state_q;
    skid_state_t      state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_d;
    logic             push;
    logic             pop;

    // All outputs decode the registered state only.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign count     = skid_count(state_q);
    assign out_data  = main_q;

    // Flush suppresses both handshakes so nothing is accepted or consumed
    // in the cycle the stage is being emptied.
    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~stall & ~flush;

    // Next occupancy and payload; flush empties the stage, and with
    // CLEAR_ON_FLUSH set any entry leaving the stage is also zeroed so that
    // out_data reads 0 whenever the stage is empty.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            if (CLEAR_ON_FLUSH) begin
                main_d = '0;
                skid_d = '0;
            end
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_d = in_data;
                    end else if (push) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (pop) begin
                        state_d = EMPTY;
                        if (CLEAR_ON_FLUSH) begin
                            main_d = '0;
                        end
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d = ONE;
                        main_d  = skid_q;
                        if (CLEAR_ON_FLUSH) begin
                            skid_d = '0;
                        end
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // Register stage; reset empties the stage and zeroes both entries
    // regardless of CLEAR_ON_FLUSH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: two 8-bit instances (clearing and
// non-clearing) share stimulus and are compared each cycle against a
// queue-based reference of the stage contents.
module tb_pipe_skid_reg;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       stall;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [1:0] count;

    logic       nc_in_ready;
    logic       nc_out_valid;
    logic [7:0] nc_out_data;
    logic [1:0] nc_count;

    logic [7:0] sb_q[$];
    logic [7:0] nc_main;
    int         n_checks;
    int         n_fail;

    pipe_skid_reg #(.WIDTH(8), .CLEAR_ON_FLUSH(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .stall     (stall),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count)
    );

    pipe_skid_reg #(.WIDTH(8), .CLEAR_ON_FLUSH(1'b0)) dut_nc (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .stall     (stall),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (nc_in_ready),
        .out_valid (nc_out_valid),
        .out_data  (nc_out_data),
        .out_ready (out_ready),
        .count     (nc_count)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, compare outputs to the reference, clock,
    // then advance the reference by the handshakes it predicts.
    task automatic applyStimulus(input logic r, input logic f, input logic s,
                                 input logic iv, input logic [7:0] d, input logic ordy);
        logic       exp_push;
        logic       exp_pop;
        logic [7:0] exp_head;
        logic [1:0] exp_cnt;
        rst       = r;
        flush     = f;
        stall     = s;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        exp_cnt   = 2'(sb_q.size());
        exp_head  = (sb_q.size() > 0) ? sb_q[0] : 8'h00;
        checkOutput("count",        {30'b0, count},        {30'b0, exp_cnt});
        checkOutput("in_ready",     {31'b0, in_ready},     {31'b0, (exp_cnt != 2'd2)});
        checkOutput("out_valid",    {31'b0, out_valid},    {31'b0, (exp_cnt != 2'd0)});
        checkOutput("out_data",     {24'b0, out_data},     {24'b0, exp_head});
        checkOutput("nc_out_valid", {31'b0, nc_out_valid}, {31'b0, (exp_cnt != 2'd0)});
        checkOutput("nc_out_data",  {24'b0, nc_out_data},
                    {24'b0, (sb_q.size() > 0) ? sb_q[0] : nc_main});
        exp_push = !r && !f && iv && (exp_cnt != 2'd2);
        exp_pop  = !r && !f && ordy && !s && (exp_cnt != 2'd0);
        @(posedge clk);
        #1;
        if (r || f) begin
            sb_q.delete();
        end else begin
            if (exp_pop)  void'(sb_q.pop_front());
            if (exp_push) sb_q.push_back(d);
        end
        if (r)                    nc_main = 8'h00;
        else if (sb_q.size() > 0) nc_main = sb_q[0];
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        nc_main   = 8'h00;
        rst       = 1'b1;
        flush     = 1'b0;
        stall     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;

        // First reset edge brings the DUTs out of X; no checks before it.
        @(posedge clk);
        #1;
        $display("[TB] reset");
        applyStimulus(1, 0, 0, 0, 8'h00, 0);

        $display("[TB] back-to-back stream");
        applyStimulus(0, 0, 0, 1, 8'h11, 1);
        applyStimulus(0, 0, 0, 1, 8'h22, 1);
        applyStimulus(0, 0, 0, 1, 8'h33, 1);
        applyStimulus(0, 0, 0, 0, 8'h00, 1);
        applyStimulus(0, 0, 0, 0, 8'h00, 1);

        $display("[TB] backpressure fill and drain");
        applyStimulus(0, 0, 0, 1, 8'hA1, 0);
        applyStimulus(0, 0, 0, 1, 8'hA2, 0);
        applyStimulus(0, 0, 0, 1, 8'hA3, 0);
        applyStimulus(0, 0, 0, 1, 8'hA3, 1);
        applyStimulus(0, 0, 0, 1, 8'hA3, 1);
        applyStimulus(0, 0, 0, 0, 8'h00, 1);
        applyStimulus(0, 0, 0, 0, 8'h00, 1);

        $display("[TB] stall while full");
        applyStimulus(0, 0, 0, 1, 8'hA1, 0);
        applyStimulus(0, 0, 0, 1, 8'hA2, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 8'h00, 1);
        applyStimulus(0, 0, 0, 0, 8'h00, 1);
        applyStimulus(0, 0, 0, 0, 8'h00, 1);
        applyStimulus(0, 0, 0, 0, 8'h00, 1);

        $display("[TB] flush while full with offered input");
        applyStimulus(0, 0, 0, 1, 8'hB1, 0);
        applyStimulus(0, 0, 0, 1, 8'hB2, 0);
        applyStimulus(0, 1, 0, 1, 8'h55, 1);
        applyStimulus(0, 0, 0, 0, 8'h00, 1);
        applyStimulus(0, 0, 0, 0, 8'h00, 1);

        $display("[TB] flush in ONE, then reset");
        applyStimulus(0, 0, 0, 1, 8'h7E, 0);
        applyStimulus(0, 1, 0, 0, 8'h00, 0);
        applyStimulus(1, 0, 0, 0, 8'h00, 0);
        applyStimulus(0, 0, 0, 0, 8'h00, 0);

        $display("[TB] reset dominates flush and stall");
        applyStimulus(0, 0, 0, 1, 8'hC1, 0);
        applyStimulus(0, 0, 0, 1, 8'hC2, 0);
        applyStimulus(1, 1, 1, 1, 8'hC3, 1);
        applyStimulus(0, 0, 0, 1, 8'hD1, 0);
        applyStimulus(0, 0, 0, 0, 8'h00, 1);
        applyStimulus(0, 0, 0, 0, 8'h00, 1);

        $display("[TB] random valid/ready run");
        for (int i = 0; i < 10000; i++) begin
            applyStimulus(1'b0,
                          ($urandom_range(0, 63) == 0),
                          ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 3) != 0),
                          8'($urandom_range(0, 255)),
                          ($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 8'h00, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
